// File: rtl/watch_pkg.sv
// Shared types and constants for the watch set-time controller.
package watch_pkg;

  typedef enum logic [2:0] {
    RUN     = 3'd0,
    SET_HR  = 3'd1,
    SET_MIN = 3'd2,
    SET_SEC = 3'd3,
    COMMIT  = 3'd4
  } state_e;

  localparam logic [1:0] FSEL_NONE = 2'd0;
  localparam logic [1:0] FSEL_HR   = 2'd1;
  localparam logic [1:0] FSEL_MIN  = 2'd2;
  localparam logic [1:0] FSEL_SEC  = 2'd3;

  // Field limits, packed BCD {tens, units}
  localparam logic [7:0] MS_MIN   = 8'h00;
  localparam logic [7:0] MS_MAX   = 8'h59;
  localparam logic [7:0] HR24_MIN = 8'h00;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MIN = 8'h01;
  localparam logic [7:0] HR12_MAX = 8'h12;

  function automatic logic is_set(input state_e s);
    return (s == SET_HR) || (s == SET_MIN) || (s == SET_SEC);
  endfunction

  // Display field selected while sitting in state s
  function automatic logic [1:0] fsel_of(input state_e s);
    case (s)
      SET_HR:  return FSEL_HR;
      SET_MIN: return FSEL_MIN;
      SET_SEC: return FSEL_SEC;
      default: return FSEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Two-digit BCD increment with wrap at max and out-of-range-to-min.
module bcd2_wrap_inc (
  input  logic [7:0] val,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  output logic [7:0] nxt
);

  logic out_rng;

  // Garbage captured from the live counters snaps to the field minimum
  always_comb begin
    out_rng = (val[7:4] > 4'd5) || (val[3:0] > 4'd9) || (val > max_val);
    if (out_rng || (val == max_val))
      nxt = min_val;
    else if (val[3:0] == 4'd9)
      nxt = {val[7:4] + 4'd1, 4'd0};
    else
      nxt = {val[7:4], val[3:0] + 4'd1};
  end

endmodule

// File: rtl/watch_set_controller.sv
// Set-time session sequencer for the watch counter chain.
// Optional build macro: WATCH_SET_AUTOREPEAT_EN (held-button auto-repeat).
module watch_set_controller
  import watch_pkg::*;
#(
  parameter bit          H24         = 1'b1,
  parameter logic [31:0] TIMEOUT_CYC = 32'd600_000_000,
  parameter logic [31:0] REPEAT_DLY  = 32'd50_000_000,
  parameter logic [31:0] REPEAT_PER  = 32'd10_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_mode,
  input  logic       btn_inc,
  input  logic       inc_held,
  input  logic [3:0] cur_hr1,
  input  logic [3:0] cur_hr0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  input  logic [3:0] cur_sec1,
  input  logic [3:0] cur_sec0,
  output logic       run_en,
  output logic       load,
  output logic [3:0] ld_hr1,
  output logic [3:0] ld_hr0,
  output logic [3:0] ld_min1,
  output logic [3:0] ld_min0,
  output logic [3:0] ld_sec1,
  output logic [3:0] ld_sec0,
  output logic [1:0] field_sel
);

  localparam logic [7:0] HR_MIN = H24 ? HR24_MIN : HR12_MIN;
  localparam logic [7:0] HR_MAX = H24 ? HR24_MAX : HR12_MAX;
  localparam logic [7:0] HR_RST = H24 ? 8'h00 : 8'h12;

  state_e      state, nxt;
  logic [7:0]  hr, mn, sc;
  logic [7:0]  fld_cur, fld_min, fld_max, fld_inc;
  logic [31:0] tcnt, tcnt_nxt;
  logic        set_st, eff_inc, rpt_fire, tmo_hit;

  assign set_st  = is_set(state);
  // mode wins over any increment source in the same cycle
  assign eff_inc = set_st && !btn_mode && (btn_inc || rpt_fire);
  assign tmo_hit = (tcnt == TIMEOUT_CYC - 32'd1);

`ifdef WATCH_SET_AUTOREPEAT_EN
  logic [31:0] rcnt;
  logic        rpt_per;

  assign rpt_fire = set_st && inc_held && !btn_mode &&
                    (rcnt + 32'd1 == (rpt_per ? REPEAT_PER : REPEAT_DLY));

  // Hold counter: first fire after REPEAT_DLY, then every REPEAT_PER
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt    <= '0;
      rpt_per <= 1'b0;
    end else if (!set_st || !inc_held || (nxt != state)) begin
      rcnt    <= '0;
      rpt_per <= 1'b0;
    end else if (rpt_fire) begin
      rcnt    <= '0;
      rpt_per <= 1'b1;
    end else begin
      rcnt    <= rcnt + 32'd1;
    end
  end
`else
  logic unused_rpt;
  assign rpt_fire   = 1'b0;
  assign unused_rpt = inc_held ^ (^REPEAT_DLY) ^ (^REPEAT_PER);
`endif

  // Select the field being edited and its limits for the shared incrementer
  always_comb begin
    fld_cur = sc;
    fld_min = MS_MIN;
    fld_max = MS_MAX;
    case (field_sel)
      FSEL_HR:  begin fld_cur = hr; fld_min = HR_MIN; fld_max = HR_MAX; end
      FSEL_MIN: fld_cur = mn;
      default:  ;
    endcase
  end

  bcd2_wrap_inc u_inc (
    .val     (fld_cur),
    .min_val (fld_min),
    .max_val (fld_max),
    .nxt     (fld_inc)
  );

  // Next state and idle-timeout counter
  always_comb begin
    nxt = state;
    unique case (state)
      RUN:                      if (btn_mode) nxt = SET_HR;
      SET_HR, SET_MIN, SET_SEC: begin
        if (btn_mode)                nxt = state_e'(state + 3'd1);
        else if (!eff_inc && tmo_hit) nxt = RUN;
      end
      COMMIT:                   nxt = RUN;
      default:                  nxt = RUN;
    endcase
    tcnt_nxt = (set_st && (nxt == state) && !eff_inc) ? tcnt + 32'd1 : '0;
  end

  // State register and registered control outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= RUN;
      run_en    <= 1'b1;
      load      <= 1'b0;
      field_sel <= FSEL_NONE;
      tcnt      <= '0;
    end else begin
      state     <= nxt;
      run_en    <= (nxt == RUN);
      load      <= (nxt == COMMIT);
      field_sel <= fsel_of(nxt);
      tcnt      <= tcnt_nxt;
    end
  end

  // Edit registers: capture on session entry, then per-field increments
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hr <= HR_RST;
      mn <= 8'h00;
      sc <= 8'h00;
    end else if ((state == RUN) && btn_mode) begin
      hr <= {cur_hr1, cur_hr0};
      mn <= {cur_min1, cur_min0};
      sc <= {cur_sec1, cur_sec0};
    end else if (eff_inc) begin
      case (field_sel)
        FSEL_HR:  hr <= fld_inc;
        FSEL_MIN: mn <= fld_inc;
        FSEL_SEC: sc <= fld_inc;
        default:  ;
      endcase
    end
  end

  assign {ld_hr1, ld_hr0}   = hr;
  assign {ld_min1, ld_min0} = mn;
  assign {ld_sec1, ld_sec0} = sc;

endmodule

// File: tb/tb_watch_set_controller.sv
// Scoreboard bench: two instances (24h and 12h) driven in lockstep.
module tb_watch_set_controller;

  localparam int TO = 16;
  localparam int RD = 8;
  localparam int RP = 4;

  typedef struct packed {
    logic        run_en;
    logic        load;
    logic [1:0]  fsel;
    logic [23:0] ld;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_mode, btn_inc, inc_held;
  logic [3:0] cur_d [6];
  logic       run_en_o [2];
  logic       load_o   [2];
  logic [1:0] fsel_o   [2];
  logic [3:0] ldd      [2][6];

  int n_vec = 0;
  int n_err = 0;

  exp_t q0[$];
  exp_t q1[$];

  // model state: phase 0 run, 1..3 editing hr/min/sec, 4 commit
  int         phase [2];
  int         idle  [2];
  int         hc    [2];
  logic [3:0] ed    [2][6];

  always #5 clk = ~clk;

  watch_set_controller #(.H24(1'b1), .TIMEOUT_CYC(32'd16), .REPEAT_DLY(32'd8), .REPEAT_PER(32'd4)) u24 (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .inc_held(inc_held),
    .cur_hr1(cur_d[0]), .cur_hr0(cur_d[1]), .cur_min1(cur_d[2]), .cur_min0(cur_d[3]),
    .cur_sec1(cur_d[4]), .cur_sec0(cur_d[5]),
    .run_en(run_en_o[0]), .load(load_o[0]),
    .ld_hr1(ldd[0][0]), .ld_hr0(ldd[0][1]), .ld_min1(ldd[0][2]), .ld_min0(ldd[0][3]),
    .ld_sec1(ldd[0][4]), .ld_sec0(ldd[0][5]), .field_sel(fsel_o[0]));

  watch_set_controller #(.H24(1'b0), .TIMEOUT_CYC(32'd16), .REPEAT_DLY(32'd8), .REPEAT_PER(32'd4)) u12 (
    .clk(clk), .reset(reset), .btn_mode(btn_mode), .btn_inc(btn_inc), .inc_held(inc_held),
    .cur_hr1(cur_d[0]), .cur_hr0(cur_d[1]), .cur_min1(cur_d[2]), .cur_min0(cur_d[3]),
    .cur_sec1(cur_d[4]), .cur_sec0(cur_d[5]),
    .run_en(run_en_o[1]), .load(load_o[1]),
    .ld_hr1(ldd[1][0]), .ld_hr0(ldd[1][1]), .ld_min1(ldd[1][2]), .ld_min0(ldd[1][3]),
    .ld_sec1(ldd[1][4]), .ld_sec0(ldd[1][5]), .field_sel(fsel_o[1]));

  function automatic logic [23:0] act_ld(input int d);
    return {ldd[d][0], ldd[d][1], ldd[d][2], ldd[d][3], ldd[d][4], ldd[d][5]};
  endfunction

  function automatic exp_t act_out(input int d);
    exp_t a;
    a.run_en = run_en_o[d];
    a.load   = load_o[d];
    a.fsel   = fsel_o[d];
    a.ld     = act_ld(d);
    return a;
  endfunction

  // Field increment by value arithmetic: wrap past hi, bad input snaps to lo
  function automatic logic [7:0] inc_f(input logic [7:0] v, input int lo, input int hi);
    int t, u, n;
    t = int'(v[7:4]);
    u = int'(v[3:0]);
    n = t * 10 + u;
    if (t > 5 || u > 9 || n >= hi) n = lo;
    else n = n + 1;
    return {4'(n / 10), 4'(n % 10)};
  endfunction

  task automatic push_exp();
    for (int d = 0; d < 2; d++) begin
      exp_t e;
      e.run_en = (phase[d] == 0);
      e.load   = (phase[d] == 4);
      e.fsel   = (phase[d] >= 1 && phase[d] <= 3) ? 2'(phase[d]) : 2'd0;
      e.ld     = {ed[d][0], ed[d][1], ed[d][2], ed[d][3], ed[d][4], ed[d][5]};
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      phase[d] = 0; idle[d] = 0; hc[d] = 0;
      for (int k = 0; k < 6; k++) ed[d][k] = 4'd0;
      if (d == 1) begin ed[d][0] = 4'd1; ed[d][1] = 4'd2; end
    end
  endtask

  task automatic model_step(input bit m, input bit i, input bit h);
    for (int d = 0; d < 2; d++) begin
      int prev, idx, lo, hi;
      bit fire;
      logic [7:0] v;
      prev = phase[d];
      fire = 1'b0;
`ifdef WATCH_SET_AUTOREPEAT_EN
      if (prev >= 1 && prev <= 3 && h && !m) begin
        hc[d]++;
        fire = (hc[d] == RD) || (hc[d] > RD && ((hc[d] - RD) % RP) == 0);
      end
`endif
      if (prev == 0) begin
        if (m) begin
          for (int k = 0; k < 6; k++) ed[d][k] = cur_d[k];
          phase[d] = 1; idle[d] = 0;
        end
      end else if (prev == 4) begin
        phase[d] = 0;
      end else if (m) begin
        phase[d] = prev + 1; idle[d] = 0;
      end else if (i || fire) begin
        idx = (prev - 1) * 2;
        lo  = (prev == 1 && d == 1) ? 1 : 0;
        hi  = (prev == 1) ? ((d == 0) ? 23 : 12) : 59;
        v   = inc_f({ed[d][idx], ed[d][idx+1]}, lo, hi);
        ed[d][idx] = v[7:4]; ed[d][idx+1] = v[3:0];
        idle[d] = 0;
      end else begin
        idle[d]++;
        if (idle[d] == TO) phase[d] = 0;
      end
      if (phase[d] != prev || !h) hc[d] = 0;
    end
    push_exp();
  endtask

  task automatic step(input bit m, input bit i, input bit h);
    btn_mode = m; btn_inc = i; inc_held = h;
    @(posedge clk);
    #1;
    model_step(m, i, h);
    btn_mode = 1'b0; btn_inc = 1'b0;
  endtask

  task automatic set_cur(input logic [23:0] v);
    for (int k = 0; k < 6; k++) cur_d[k] = v[23 - 4*k -: 4];
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Monitor: every registered output snapshot is checked against the scoreboard
  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q0.size() > 0) begin
        e = q0.pop_front(); a = act_out(0); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL cyc_h24 at %0t: got %h want %h", $time, a, e); end
      end
      if (q1.size() > 0) begin
        e = q1.pop_front(); a = act_out(1); n_vec++;
        if (a !== e) begin n_err++; $display("FAIL cyc_h12 at %0t: got %h want %h", $time, a, e); end
      end
    end
  end

  function automatic logic [3:0] rdig(input int mx);
    if ($urandom_range(0, 9) == 0) return 4'($urandom_range(0, 15));
    return 4'($urandom_range(0, mx));
  endfunction

  initial begin
    int k;
    reset = 1'b1; btn_mode = 1'b0; btn_inc = 1'b0; inc_held = 1'b0;
    set_cur(24'h000000);
    model_reset();
    push_exp();
    @(negedge clk);
    chk("rst_run_en", {31'd0, run_en_o[0]}, 32'd1);
    chk("rst_ld_h12", {8'd0, act_ld(1)}, 32'h120000);
    #2 reset = 1'b0;

    // full session from 13:45:07
    set_cur(24'h134507);
    step(1, 0, 0); step(0, 1, 0); step(0, 1, 0);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("session_ld", {8'd0, act_ld(0)}, 32'h154507);

    // wraps at 23:59:09
    set_cur(24'h235909);
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 0, 0);
    chk("wrap_h24", {8'd0, act_ld(0)}, 32'h000010);
    chk("wrap_h12", {8'd0, act_ld(1)}, 32'h010010);

    // 12 o'clock in 12h mode, junk minute 7A
    set_cur(24'h127A00);
    step(1, 0, 0); step(0, 1, 0); step(1, 0, 0); step(0, 1, 0);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);
    chk("hr12_wrap", {8'd0, act_ld(1)}, 32'h010000);
    chk("junk_min", {24'd0, ldd[0][2], ldd[0][3]}, 32'h00);

    // mode and inc together: field advances, hour untouched
    set_cur(24'h050000);
    step(1, 0, 0); step(1, 1, 0);
    chk("simul_fsel", {30'd0, fsel_o[0]}, 32'd2);
    chk("simul_hr", {24'd0, ldd[0][0], ldd[0][1]}, 32'h05);
    step(1, 0, 0); step(1, 0, 0); step(0, 0, 0);

    // idle timeout aborts without load
    set_cur(24'h101010);
    step(1, 0, 0); step(0, 1, 0);
    repeat (15) step(0, 0, 0);
    chk("tmo_pending", {31'd0, run_en_o[0]}, 32'd0);
    step(0, 0, 0);
    chk("tmo_run_en", {31'd0, run_en_o[0]}, 32'd1);
    chk("tmo_kept", {8'd0, act_ld(0)}, 32'h111010);

    // asynchronous reset in the middle of a session
    step(1, 0, 0); step(1, 0, 0);
    #2 reset = 1'b1;
    #1;
    chk("arst_run_en", {31'd0, run_en_o[0]}, 32'd1);
    chk("arst_fsel", {30'd0, fsel_o[0]}, 32'd0);
    chk("arst_load", {31'd0, load_o[1]}, 32'd0);
    chk("arst_ld12", {8'd0, act_ld(1)}, 32'h120000);
    model_reset();
    q0.delete(); q1.delete();
    push_exp();
    #5 reset = 1'b0;

`ifdef WATCH_SET_AUTOREPEAT_EN
    set_cur(24'h000000);
    step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
    repeat (18) step(0, 0, 1);
    step(0, 0, 0);
    chk("autorep_sec", {24'd0, ldd[0][4], ldd[0][5]}, 32'h03);
    step(1, 0, 0); step(0, 0, 0);
`endif

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cur_d[0] = rdig(2); cur_d[1] = rdig(9); cur_d[2] = rdig(5);
        cur_d[3] = rdig(9); cur_d[4] = rdig(5); cur_d[5] = rdig(9);
      end
      step($urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) != 0);
    end
    inc_held = 1'b0;

    k = 0;
    while ((q0.size() > 0 || q1.size() > 0) && k < 10) begin
      @(negedge clk);
      k++;
    end
    #1;
    if (q0.size() > 0 || q1.size() > 0) begin
      n_vec++; n_err++;
      $display("FAIL drain: %0d entries left, want 0", q0.size() + q1.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
